// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the APB master that talks to the SPI register block.
//   ADDR_W / DATA_W : APB address and data widths
//   CR1..DR         : register addresses of the SPI APB slave
//   apb_state_t     : APB master FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] CR1 = 3'd0;
  localparam logic [ADDR_W-1:0] CR2 = 3'd1;
  localparam logic [ADDR_W-1:0] BR  = 3'd2;
  localparam logic [ADDR_W-1:0] SR  = 3'd3;
  localparam logic [ADDR_W-1:0] DR  = 3'd5;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ---------------------------------------------------------------------------
// apb_timeout_counter
// Counts ACCESS cycles without PREADY and flags the cycle whose count step
// reaches LIMIT. Only instantiated when APB_TIMEOUT_EN is defined.
// Ports:
//   PCLK    in   APB clock
//   PRESETn in   asynchronous active-low reset
//   clear   in   restart the count (SETUP entry)
//   inc     in   an ACCESS cycle with PREADY=0
//   expire  out  this increment brings the count to LIMIT
// ---------------------------------------------------------------------------
module apb_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // Saturates at LIMIT so a stuck increment can never wrap back to zero.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the FSM leaves ACCESS on the same edge the count hits LIMIT.
  assign expire = inc && (count == W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_interface.sv
// ---------------------------------------------------------------------------
// apb_master_interface
// Converts single local commands into APB3 transfers (IDLE/SETUP/ACCESS/RESP)
// and returns a one-cycle registered response pulse.
// Optional feature macro: APB_TIMEOUT_EN -- aborts an ACCESS phase after
// TIMEOUT_CYCLES cycles without PREADY.
// Ports:
//   PCLK, PRESETn                       clock, async active-low reset
//   cmd_valid/cmd_ready                 command handshake
//   cmd_write, cmd_addr, cmd_wdata      command payload
//   rsp_valid, rsp_rdata, rsp_err,      response (pulse + held status)
//   rsp_timeout
//   PSEL, PENABLE, PWRITE, PADDR,       APB request
//   PWDATA
//   PRDATA, PREADY, PSLVERR             APB completion
// ---------------------------------------------------------------------------
module apb_master_interface
  import spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam logic [1:0] IDLE   = APB_IDLE;
  localparam logic [1:0] SETUP  = APB_SETUP;
  localparam logic [1:0] ACCESS = APB_ACCESS;
  localparam logic [1:0] RESP   = APB_RESP;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       accept;
  logic       timeout_hit;
  logic       access_done;

  // cmd_ready is low during the first cycle after reset, so the handshake
  // needs it explicitly rather than just state==IDLE.
  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  assign access_done = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (accept),
    .inc     ((state == ACCESS) && !PREADY),
    .expire  (timeout_hit)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_timeout <= 1'b0;
    end else if (access_done) begin
      rsp_timeout <= 1'b0;
    end else if ((state == ACCESS) && timeout_hit) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All APB and response outputs are decoded from next_state so they are
  // registered yet line up with the state they describe.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == IDLE);
      PSEL      <= (next_state == SETUP) || (next_state == ACCESS);
      PENABLE   <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (access_done) begin
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if ((state == ACCESS) && timeout_hit) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_master_interface.md
APB_MASTER_INTERFACE -- requirements
Module: apb_master_interface

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of ACCESS cycles without PREADY before abort; it is used only when APB_TIMEOUT_EN is defined.
REQ-002 PCLK  input  1  APB clock; all state changes on the rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  the local requester offers a command.
REQ-005 cmd_ready  output  1  the block accepts a command; a transfer happens when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  3  register address (CR1=0, CR2=1, BR=2, SR=3, DR=5).
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  captured PRDATA; 0 for writes.
REQ-011 rsp_err  output  1  PSLVERR was sampled, or the transfer timed out.
REQ-012 rsp_timeout  output  1  the transfer was aborted by timeout.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-014 PADDR  output  3  APB address.
REQ-015 PWDATA  output  8  APB write data.
REQ-016 PRDATA  input  8  read data from the responder.
REQ-017 PREADY, PSLVERR  input  1 each  responder completion and error.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, all held in registers, and all outputs SHALL be registered.
REQ-019 cmd_ready SHALL be 1 only in IDLE.
REQ-020 An accepted command in IDLE SHALL move the FSM to SETUP on that edge and latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
REQ-021 In SETUP: PSEL=1, PENABLE=0; the FSM moves unconditionally to ACCESS on the next edge.
REQ-022 In ACCESS: PSEL=1, PENABLE=1; the FSM stays in ACCESS until PREADY=1 is sampled, then moves to RESP.
REQ-023 PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the end of ACCESS.
REQ-024 At the ACCESS edge that samples PREADY=1, the block SHALL capture PRDATA (reads only) and PSLVERR.
REQ-025 In RESP: PSEL=0, PENABLE=0, rsp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 Minimum transfer latency SHALL be accept edge -> SETUP -> ACCESS -> RESP, with rsp_valid visible 3 cycles after acceptance when PREADY=1 in the first ACCESS cycle.
REQ-027 Back-to-back commands SHALL have at least one IDLE cycle between RESP and the next SETUP.
REQ-028 rsp_rdata, rsp_err and rsp_timeout SHALL hold their last values until the next RESP.
REQ-029 For a write, rsp_rdata SHALL be 8'h00.
REQ-030 PREADY and PSLVERR sampled outside ACCESS SHALL be ignored.
REQ-031 cmd_valid outside IDLE SHALL be ignored, and no command is lost or queued.

Reset
REQ-032 With PRESETn=0 the block SHALL immediately go to state IDLE and drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0 and the timeout counter to 0, even mid-transfer.
REQ-033 cmd_ready SHALL be 0 while PRESETn=0 and 1 on the first PCLK edge after release.

Configuration
REQ-034 With macro APB_TIMEOUT_EN defined, a counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0.
REQ-035 With APB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-036 With APB_TIMEOUT_EN defined, PREADY=1 on the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete the transfer normally.
REQ-037 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_timeout SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-038 Shared package spi_pkg SHALL hold the register address constants (CR1, CR2, BR, SR, DR), the APB master state enum type, and the width constants ADDR_W=3 and DATA_W=8.
REQ-039 The timeout counter SHALL be a sub-module, apb_timeout_counter, instantiated only under APB_TIMEOUT_EN; all other logic stays in a single module.

Verification
REQ-040 Write addr 0 data A5 with PREADY tied 1 -> PSEL rises 1 cycle after accept, PENABLE 1 cycle later, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=00.
REQ-041 Read addr 5 with responder PRDATA=5C and PREADY delayed 4 ACCESS cycles -> PADDR and PWRITE stable throughout, rsp_rdata=5C, rsp_valid after the PREADY edge.
REQ-042 Write addr 5 with PSLVERR=1 at the PREADY cycle -> rsp_err=1, rsp_timeout=0; the next command's cmd_ready returns 1 after RESP.
REQ-043 With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_timeout=1; PREADY=1 at exactly cycle 16 -> normal completion.
REQ-044 PRESETn asserted during ACCESS -> PSEL and PENABLE are 0 immediately with no rsp_valid; after release, a read of addr 0 returns the responder value.
REQ-045 Against the SPI APB slave: write CR1=0x54, then read CR1 -> rsp_rdata=0x54; cmd_valid held high through a transfer -> exactly one transfer per IDLE.
